keypad_scanner: RTL and testbench

- Upstream front-end for the 4-digit code lock.
- Scans a 4x4 matrix keypad, synchronizes and debounces the row returns, and encodes the pressed key to a 4-bit hex code.
- Emits exactly one single-cycle valid_key pulse per debounced press, plus the key code; the lock consumes these directly (key[3:0], valid_key).

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/sync2.sv | 24 ++
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key code constants and row-decoding helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        WAIT_RELEASE
    } state_t;

    localparam logic [3:0] KEY_START  = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CHANGE = 4'hE;

    localparam int SYNC_STAGES = 2;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (onehot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs; both stages clear on rst.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments so q takes the old meta, giving two real stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, one valid_key pulse per press.
// Optional auto-repeat while a key is held is built when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key,
    output logic       valid_key
);

    // The row sample is taken once SCAN_CYCLES of drive have made it through the synchronizer.
    localparam int DWELL_LAST = SCAN_CYCLES + SYNC_STAGES - 1;
    localparam int DWELL_W    = $clog2(DWELL_LAST + 1);
    localparam int DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_LAST);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [DEB_W-1:0]   rel_q, rel_d;
    logic [3:0]         row_cap_q, row_cap_d;
    logic [3:0]         key_d;
    logic               valid_d;
    logic [3:0]         row_s;
    logic               match;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    sync2 #(.WIDTH(4)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_i),
        .q   (row_s)
    );

    assign match = (row_s == row_cap_q);
    assign col_o = 4'b0001 << col_q;

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dwell_d   = '0;
        deb_d     = deb_q;
        rel_d     = rel_q;
        row_cap_d = row_cap_q;
        key_d     = key;
        valid_d   = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_MAX) begin
                    if (is_onehot(row_s)) begin
                        row_cap_d = row_s;
                        deb_d     = DEB_W'(1);
                        state_d   = (DEBOUNCE_CYCLES == 1) ? EMIT : DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!match) begin
                    state_d = SCAN;
                    deb_d   = '0;
                end else if (deb_q == DEB_MAX) begin
                    state_d = EMIT;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            EMIT: begin
                state_d = WAIT_RELEASE;
                deb_d   = '0;
                rel_d   = '0;
`ifdef KEYPAD_REPEAT_EN
                rep_d   = '0;
`endif
            end
            WAIT_RELEASE: begin
                if (row_s != 4'd0) begin
                    rel_d = '0;
                end else if (rel_q == DEB_MAX) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + DEB_W'(1);
                end
`ifdef KEYPAD_REPEAT_EN
                if (!match) begin
                    rep_d = '0;
                end else if (rep_q == REP_MAX) begin
                    rep_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    rep_d = rep_q + REP_W'(1);
                end
`endif
            end
            default: state_d = SCAN;
        endcase

        if (state_d == EMIT) begin
            valid_d = 1'b1;
            key_d   = {onehot_to_idx(row_cap_d), col_d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCAN;
            col_q     <= 2'd0;
            dwell_q   <= '0;
            deb_q     <= '0;
            rel_q     <= '0;
            row_cap_q <= 4'd0;
            key       <= 4'h0;
            valid_key <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            rel_q     <= rel_d;
            row_cap_q <= row_cap_d;
            key       <= key_d;
            valid_key <= valid_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-aware keypad model (default parameters).
// Expected pulse counts switch on KEYPAD_REPEAT_EN.
module tb_keypad_scanner;
    import keypad_pkg::*;

    // Each column is driven for SCAN_CYCLES settle cycles plus two synchronizer stages.
    localparam int DWELL = 4;
`ifdef KEYPAD_REPEAT_EN
    localparam int HOLD_PULSES = 4;
`else
    localparam int HOLD_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key;
    logic       valid_key;

    logic       contact    = 1'b0;
    logic [3:0] press_rows = 4'd0;
    logic [1:0] press_col  = 2'd0;

    int         n_checks   = 0;
    int         n_fail     = 0;
    int         pulse_cnt  = 0;
    int         double_cnt = 0;
    logic [3:0] last_key   = 4'd0;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    assign row_i = (contact && (col_o == (4'b0001 << press_col))) ? press_rows : 4'b0000;

    keypad_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .row_i     (row_i),
        .col_o     (col_o),
        .key       (key),
        .valid_key (valid_key)
    );

    always @(negedge clk) begin
        if (valid_key) begin
            pulse_cnt = pulse_cnt + 1;
            last_key  = key;
            if (prev_valid) double_cnt = double_cnt + 1;
        end
        prev_valid = valid_key;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lands on the first cycle a fresh visit to the target column is driven.
    task automatic wait_col(input string tag, input logic [3:0] target);
        int n = 0;
        while (col_o === target && n < 64) begin @(negedge clk); n++; end
        while (col_o !== target && n < 64) begin @(negedge clk); n++; end
        if (col_o !== target) check({tag, " timeout"}, col_o, target);
    endtask

    task automatic wait_pulse(input string tag);
        int n = 0;
        while (valid_key !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (valid_key !== 1'b1) check({tag, " timeout"}, valid_key, 1);
    endtask

    initial begin
        int base;
        int n;

        #2 rst = 1'b1;
        #1;
        check("reset col", col_o, 4'b0001);
        check("reset key", key, 4'h0);
        check("reset valid", valid_key, 0);
        cycles(3);
        rst = 1'b0;

        // Clean press of row 2 / col 3, then a clean release
        press_col = 2'd3; press_rows = 4'b0100;
        base = pulse_cnt;
        wait_col("clean", 4'b1000);
        contact = 1'b1;
        cycles(20);
        contact = 1'b0;
        cycles(5);
        check("release holds col", col_o, 4'b1000);
        cycles(1);
        check("release next col", col_o, 4'b0001);
        cycles(10);
        check("clean pulses", pulse_cnt - base, 1);
        check("clean key", last_key, KEY_START);
        check("key holds", key, 4'hB);

        // Asynchronous reset in the middle of scanning column 2
        wait_col("mid", 4'b0100);
        cycles(1);
        #2 rst = 1'b1;
        #1;
        check("async col", col_o, 4'b0001);
        check("async key", key, 4'h0);
        check("async valid", valid_key, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (col_o === 4'b0001 && n < 20) begin @(negedge clk); n++; end
        check("advance cycles", n, DWELL);
        check("advance col", col_o, 4'b0010);

        // Bouncing contact on row 0 / col 0: 2 on, 1 off, 2 on, then stable
        press_col = 2'd0; press_rows = 4'b0001;
        base = pulse_cnt;
        wait_col("bounce", 4'b0001);
        contact = 1'b1; cycles(2);
        contact = 1'b0; cycles(1);
        contact = 1'b1; cycles(2);
        check("bounce early pulses", pulse_cnt - base, 0);
        n = 0;
        while (valid_key !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        check("bounce latency", n, 7);
        cycles(10);
        contact = 1'b0;
        cycles(10);
        check("bounce pulses", pulse_cnt - base, 1);
        check("bounce key", last_key, 4'h0);

        // Two rows together on col 2 are ignored and scanning moves on
        press_col = 2'd2; press_rows = 4'b0011;
        base = pulse_cnt;
        wait_col("multi", 4'b0100);
        contact = 1'b1;
        cycles(DWELL);
        check("multi next col", col_o, 4'b1000);
        cycles(30);
        check("multi pulses", pulse_cnt - base, 0);
        contact = 1'b0;

        // Key 5 with a 2-cycle dropout while held, then a clean release
        press_col = 2'd1; press_rows = 4'b0010;
        base = pulse_cnt;
        wait_col("rel", 4'b0010);
        contact = 1'b1;
        wait_pulse("rel pulse");
        cycles(8);
        contact = 1'b0; cycles(2);
        contact = 1'b1; cycles(8);
        contact = 1'b0;
        cycles(5);
        check("rel holds col", col_o, 4'b0010);
        cycles(1);
        check("rel next col", col_o, 4'b0100);
        cycles(5);
        check("rel pulses", pulse_cnt - base, 1);
        check("rel key", last_key, 4'h5);

        // Key C held 60 cycles after acceptance
        press_col = 2'd0; press_rows = 4'b1000;
        base = pulse_cnt;
        wait_col("hold", 4'b0001);
        contact = 1'b1;
        wait_pulse("hold pulse");
        cycles(60);
        contact = 1'b0;
        cycles(20);
        check("hold pulses", pulse_cnt - base, HOLD_PULSES);
        check("hold key", last_key, KEY_ENTER);

        // Reset while key E is held: re-detected once after reset release
        press_col = 2'd2; press_rows = 4'b1000;
        wait_col("held", 4'b0100);
        contact = 1'b1;
        wait_pulse("held first");
        cycles(5);
        base = pulse_cnt;
        #2 rst = 1'b1;
        #1;
        check("held reset key", key, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_pulse("held again");
        cycles(3);
        contact = 1'b0;
        cycles(10);
        check("held pulses", pulse_cnt - base, 1);
        check("held key", last_key, KEY_CHANGE);

        check("back-to-back pulses", double_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
